// File: rtl/vector_regfile_seq.sv
// Parametrised vector register file: two combinational read ports, a sequenced
// beat-wise load port with busy scoreboard, and a masked single/paired ALU write port.
module vector_regfile_seq #(
  parameter int NUM_REGS = 8,
  parameter int VLEN     = 512,
  parameter int ELEM_W   = 32,
  parameter int BEAT_W   = 64,
  localparam int RW      = $clog2(NUM_REGS),
  localparam int NBEATS  = VLEN / BEAT_W,
  localparam int NELEM   = VLEN / ELEM_W,
  localparam int CW      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_start,
  input  logic [RW-1:0]       ld_reg,
  output logic                ld_start_ready,
  input  logic                ld_valid,
  input  logic [BEAT_W-1:0]   ld_data,
  output logic                ld_ready,
  output logic                ld_done,
  input  logic                alu_we,
  input  logic                alu_pair,
  input  logic [RW-1:0]       alu_waddr,
  input  logic [VLEN-1:0]     alu_wdata0,
  input  logic [VLEN-1:0]     alu_wdata1,
  input  logic [NELEM-1:0]    alu_mask,
  input  logic [RW-1:0]       rd_addr_a,
  output logic [VLEN-1:0]     rd_data_a,
  input  logic [RW-1:0]       rd_addr_b,
  output logic [VLEN-1:0]     rd_data_b,
  output logic [NUM_REGS-1:0] busy_map
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   lreg_q, lreg_d;
  logic            done_q, done_d;
  logic            beat_acc;
  logic [RW-1:0]   pair_addr;

  logic [VLEN-1:0] regs_q [NUM_REGS];
  logic [VLEN-1:0] wr_en  [NUM_REGS];
  logic [VLEN-1:0] wr_val [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lreg_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lreg_q  <= lreg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lreg_d         = lreg_q;
    done_d         = 1'b0;
    ld_ready       = 1'b0;
    ld_start_ready = 1'b0;
    beat_acc       = 1'b0;
    unique case (state_q)
      IDLE: begin
        ld_start_ready = 1'b1;
        if (ld_start) begin
          state_d = LOAD;
          lreg_d  = ld_reg;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          beat_acc = 1'b1;
          if (cnt_q == CW'(NBEATS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_done = done_q;

  // Busy bit tracks the LOAD state directly, so it sets and clears on the same edges.
  always_comb begin
    busy_map = '0;
    if (state_q == LOAD) busy_map[lreg_q] = 1'b1;
  end

  // RW-bit add wraps NUM_REGS-1 onto register 0.
  assign pair_addr = alu_waddr + 1'b1;

  // Load beat is applied first, ALU elements overlay it so the ALU wins per element.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      wr_en[r]  = '0;
      wr_val[r] = '0;
      if (beat_acc && (lreg_q == RW'(r))) begin
        wr_en[r][int'(cnt_q)*BEAT_W +: BEAT_W]  = '1;
        wr_val[r][int'(cnt_q)*BEAT_W +: BEAT_W] = ld_data;
      end
      if (alu_we) begin
        for (int unsigned e = 0; e < NELEM; e++) begin
          if (alu_mask[e]) begin
            if (alu_waddr == RW'(r)) begin
              wr_en[r][e*ELEM_W +: ELEM_W]  = '1;
              wr_val[r][e*ELEM_W +: ELEM_W] = alu_wdata0[e*ELEM_W +: ELEM_W];
            end else if (alu_pair && (pair_addr == RW'(r))) begin
              wr_en[r][e*ELEM_W +: ELEM_W]  = '1;
              wr_val[r][e*ELEM_W +: ELEM_W] = alu_wdata1[e*ELEM_W +: ELEM_W];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        regs_q[r] <= (regs_q[r] & ~wr_en[r]) | wr_val[r];
    end
  end

  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];

endmodule

// File: tb/tb_vector_regfile_seq.sv
// Self-checking bench for vector_regfile_seq: vector table, directed corner sequences,
// and randomized traffic checked against an array-based reference model.
module tb_vector_regfile_seq;
  localparam int NR = 8;
  localparam int VL = 512;
  localparam int EW = 32;
  localparam int BW = 64;
  localparam int NB = VL / BW;
  localparam int NE = VL / EW;

  logic          clk, rst_n;
  logic          ld_start, ld_start_ready, ld_valid, ld_ready, ld_done;
  logic [2:0]    ld_reg, alu_waddr, rd_addr_a, rd_addr_b;
  logic [BW-1:0] ld_data;
  logic          alu_we, alu_pair;
  logic [VL-1:0] alu_wdata0, alu_wdata1, rd_data_a, rd_data_b;
  logic [NE-1:0] alu_mask;
  logic [NR-1:0] busy_map;

  vector_regfile_seq #(.NUM_REGS(NR), .VLEN(VL), .ELEM_W(EW), .BEAT_W(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_reg(ld_reg), .ld_start_ready(ld_start_ready),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
    .alu_we(alu_we), .alu_pair(alu_pair), .alu_waddr(alu_waddr),
    .alu_wdata0(alu_wdata0), .alu_wdata1(alu_wdata1), .alu_mask(alu_mask),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .busy_map(busy_map)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  // Reference model: register contents plus load progress.
  logic [VL-1:0] m_regs [NR];
  bit m_loading;
  int m_reg;
  int m_cnt;
  bit m_done;

  typedef struct {
    bit          start;
    logic [2:0]  lreg;
    bit          valid;
    logic [63:0] data;
    logic [7:0]  e_busy;
    bit          e_done;
    bit          e_ready;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [VL-1:0] act, input logic [VL-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_loading = 0; m_reg = 0; m_cnt = 0; m_done = 0;
  endfunction

  function automatic void model_update();
    bit done;
    done = 0;
    if (!m_loading) begin
      if (ld_start) begin
        m_loading = 1; m_reg = int'(ld_reg); m_cnt = 0;
      end
    end else if (ld_valid) begin
      m_regs[m_reg][m_cnt*BW +: BW] = ld_data;
      m_cnt++;
      if (m_cnt == NB) begin
        m_cnt = 0; m_loading = 0; done = 1;
      end
    end
    if (alu_we) begin
      for (int e = 0; e < NE; e++) begin
        if (alu_mask[e]) begin
          m_regs[int'(alu_waddr)][e*EW +: EW] = alu_wdata0[e*EW +: EW];
          if (alu_pair) m_regs[(int'(alu_waddr) + 1) % NR][e*EW +: EW] = alu_wdata1[e*EW +: EW];
        end
      end
    end
    m_done = done;
  endfunction

  task automatic check_outputs();
    logic [NR-1:0] eb;
    eb = '0;
    if (m_loading) eb[m_reg] = 1'b1;
    chk("ld_ready", VL'(ld_ready), VL'(m_loading));
    chk("ld_start_ready", VL'(ld_start_ready), VL'(!m_loading));
    chk("ld_done", VL'(ld_done), VL'(m_done));
    chk("busy_map", VL'(busy_map), VL'(eb));
    for (int r = 0; r < NR; r++) begin
      rd_addr_a = 3'(r);
      rd_addr_b = 3'((r + 3) % NR);
      #1;
      chk($sformatf("rd_a[%0d]", r), rd_data_a, m_regs[r]);
      chk($sformatf("rd_b[%0d]", (r + 3) % NR), rd_data_b, m_regs[(r + 3) % NR]);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    if (ld_done) pulses++;
    check_outputs();
  endtask

  task automatic idle();
    ld_start = 0; ld_reg = '0; ld_valid = 0; ld_data = '0;
    alu_we = 0; alu_pair = 0; alu_waddr = '0; alu_mask = '0;
    alu_wdata0 = '0; alu_wdata1 = '0;
  endtask

  task automatic read_reg(input int r, output logic [VL-1:0] v);
    rd_addr_a = 3'(r);
    #1;
    v = rd_data_a;
  endtask

  function automatic logic [VL-1:0] rand_vec();
    logic [VL-1:0] v;
    for (int i = 0; i < VL / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, VL'(busy_map), '0);
    chk({tag, "_start_ready"}, VL'(ld_start_ready), VL'(1));
    chk({tag, "_ld_ready"}, VL'(ld_ready), '0);
    chk({tag, "_ld_done"}, VL'(ld_done), '0);
    for (int r = 0; r < NR; r++) begin
      rd_addr_a = 3'(r);
      rd_addr_b = 3'(NR - 1 - r);
      #1;
      chk($sformatf("%s_rd_a[%0d]", tag, r), rd_data_a, '0);
      chk($sformatf("%s_rd_b[%0d]", tag, NR - 1 - r), rd_data_b, '0);
    end
  endtask

  initial begin
    logic [VL-1:0] v;
    logic [63:0] exp_beat;

    idle();
    rd_addr_a = '0; rd_addr_b = '0;
    rst_n = 1'b0;
    model_reset();
    #5;
    reset_checks("por");
    #5 rst_n = 1'b1;

    // Full load of reg 5 from a vector table.
    tbl[0].start = 1; tbl[0].lreg = 3'd5; tbl[0].valid = 0; tbl[0].data = '0;
    tbl[0].e_busy = 8'h20; tbl[0].e_done = 0; tbl[0].e_ready = 1;
    for (int k = 0; k < 8; k++) begin
      tbl[k+1].start  = 0;
      tbl[k+1].lreg   = 3'd0;
      tbl[k+1].valid  = 1;
      tbl[k+1].data   = 64'h1111_0000_0000_0000 | 64'(k);
      tbl[k+1].e_busy = (k == 7) ? 8'h00 : 8'h20;
      tbl[k+1].e_done = (k == 7);
      tbl[k+1].e_ready = (k != 7);
    end
    tbl[9].start = 0; tbl[9].lreg = 3'd0; tbl[9].valid = 0; tbl[9].data = '0;
    tbl[9].e_busy = 8'h00; tbl[9].e_done = 0; tbl[9].e_ready = 0;

    for (int i = 0; i < 10; i++) begin
      idle();
      ld_start = tbl[i].start;
      ld_reg   = tbl[i].lreg;
      ld_valid = tbl[i].valid;
      ld_data  = tbl[i].data;
      step();
      chk($sformatf("tbl%0d_busy", i), VL'(busy_map), VL'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i), VL'(ld_done), VL'(tbl[i].e_done));
      chk($sformatf("tbl%0d_ready", i), VL'(ld_ready), VL'(tbl[i].e_ready));
    end
    read_reg(5, v);
    for (int k = 0; k < 8; k++) begin
      exp_beat = 64'h1111_0000_0000_0000 | 64'(k);
      chk($sformatf("reg5_beat%0d", k), VL'(v[k*64 +: 64]), VL'(exp_beat));
    end

    // Stalled load with a mid-load ld_start for reg 2 that must be ignored.
    idle(); ld_start = 1; ld_reg = 3'd5; step();
    pulses = 0;
    begin
      int beats;
      beats = 0;
      for (int j = 0; j < 40 && beats < NB; j++) begin
        idle();
        ld_valid = (j % 3 == 0);
        ld_data  = 64'hCAFE_0000_0000_0000 | 64'(beats);
        if (j == 4) begin ld_start = 1; ld_reg = 3'd2; end
        if (ld_valid) beats++;
        step();
        if (j == 4) chk("stall_busy_reg2_ignored", VL'(busy_map), VL'(8'h20));
      end
    end
    idle(); step(); step();
    chk("stall_done_pulses", VL'(pulses), VL'(1));

    // Masked paired write at the top register wraps onto reg 0.
    idle();
    alu_we = 1; alu_pair = 1; alu_waddr = 3'd7; alu_mask = 16'h00FF;
    alu_wdata0 = {16{32'hAAAAAAAA}};
    alu_wdata1 = {16{32'h55555555}};
    step();
    idle();
    read_reg(7, v);
    chk("pair_reg7_lo", VL'(v[255:0]), VL'({8{32'hAAAAAAAA}}));
    chk("pair_reg7_hi", VL'(v[511:256]), '0);
    read_reg(0, v);
    chk("pair_reg0_lo", VL'(v[255:0]), VL'({8{32'h55555555}}));
    chk("pair_reg0_hi", VL'(v[511:256]), '0);

    // Collision: ALU element 0 and load beat 0 both target reg 3.
    idle(); ld_start = 1; ld_reg = 3'd3; step();
    idle();
    ld_valid = 1; ld_data = 64'h0123_4567_89AB_CDEF;
    alu_we = 1; alu_waddr = 3'd3; alu_mask = 16'h0001;
    alu_wdata0 = {480'b0, 32'hDEADBEEF};
    step();
    idle();
    read_reg(3, v);
    chk("coll_lo", VL'(v[31:0]), VL'(32'hDEADBEEF));
    chk("coll_hi", VL'(v[63:32]), VL'(32'h01234567));
    pulses = 0;
    for (int k = 1; k < NB; k++) begin
      idle(); ld_valid = 1; ld_data = {32'(k), 32'hF00D_0000}; step();
    end
    idle(); step();
    chk("coll_done_pulses", VL'(pulses), VL'(1));

    // Asynchronous reset after three beats of a reg 6 load.
    idle(); ld_start = 1; ld_reg = 3'd6; step();
    for (int k = 0; k < 3; k++) begin
      idle(); ld_valid = 1; ld_data = 64'hBEEF_0000_0000_0000 | 64'(k); step();
    end
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    reset_checks("midrst");
    #2 rst_n = 1'b1;
    pulses = 0;
    step(); step(); step();
    chk("midrst_no_done", VL'(pulses), '0);
    idle(); ld_start = 1; ld_reg = 3'd6; step();
    for (int k = 0; k < NB; k++) begin
      idle(); ld_valid = 1; ld_data = 64'h7777_0000_0000_0000 | 64'(k); step();
    end
    idle(); step();
    chk("reload_done_pulses", VL'(pulses), VL'(1));

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ld_start   = ($urandom_range(0, 9) < 3);
      ld_reg     = 3'($urandom_range(0, NR - 1));
      ld_valid   = ($urandom_range(0, 9) < 6);
      ld_data    = {$urandom, $urandom};
      alu_we     = ($urandom_range(0, 9) < 4);
      alu_pair   = $urandom_range(0, 1) == 1;
      alu_waddr  = 3'($urandom_range(0, NR - 1));
      alu_mask   = ($urandom_range(0, 7) == 0) ? '0 : 16'($urandom);
      alu_wdata0 = rand_vec();
      alu_wdata1 = rand_vec();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vector_regfile_seq.md
Name: vector_regfile_seq

Overview:
- Parametrised vector register file, successor to the fixed 4x512 file.
- Provides NUM_REGS registers of VLEN bits and two combinational read ports.
- Has a sequenced beat-wise load port fed from a narrow memory stream (valid/ready) with a per-register busy scoreboard.
- Has an element-masked ALU write port with single or paired (waddr, waddr+1) writeback; sits between the memory load unit and the vector ALU.

Parameters:
NUM_REGS, 8, number of vector registers (power of 2, >=2)
VLEN, 512, bits per vector register
ELEM_W, 32, element width for ALU write mask granularity (VLEN % ELEM_W == 0)
BEAT_W, 64, load stream beat width (VLEN % BEAT_W == 0, BEAT_W <= VLEN)
Derived: RW = log2(NUM_REGS), NBEATS = VLEN/BEAT_W, NELEM = VLEN/ELEM_W, CW = log2(NBEATS) (min 1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ld_start  in  1  request a vector load into ld_reg
ld_reg  in  RW  destination register for load
ld_start_ready  out  1  high in IDLE; ld_start accepted only when high
ld_valid  in  1  load beat valid
ld_data  in  BEAT_W  load beat payload
ld_ready  out  1  high in LOAD state
ld_done  out  1  one-cycle pulse after final beat written
alu_we  in  1  ALU write enable
alu_pair  in  1  1 = also write alu_wdata1 to alu_waddr+1
alu_waddr  in  RW  ALU destination register
alu_wdata0  in  VLEN  data for alu_waddr
alu_wdata1  in  VLEN  data for alu_waddr+1
alu_mask  in  NELEM  per-element write enable (bit i -> bits [i*ELEM_W +: ELEM_W])
rd_addr_a  in  RW  read port A address
rd_data_a  out  VLEN  read port A data
rd_addr_b  in  RW  read port B address
rd_data_b  out  VLEN  read port B data
busy_map  out  NUM_REGS  bit r = register r has a load in progress

Behaviour:
- Reset (rst_n low, async): all registers 0, state IDLE, beat counter 0, latched load reg 0, ld_done 0, busy_map 0; ld_ready 0, ld_start_ready 1. Reset mid-load abandons the load; partially written beats are cleared along with everything else.
- Reads: rd_data_x = reg[rd_addr_x], combinational, no write bypass; a write is visible the cycle after its edge.
- FSM IDLE:
  - ld_start=1 latches ld_reg, clears the counter and goes to LOAD next cycle.
  - busy_map[ld_reg] is set from the same edge.
- FSM LOAD:
  - ld_ready=1, ld_start_ready=0, and ld_start is ignored.
  - On ld_valid&&ld_ready, ld_data is written to bits [cnt*BEAT_W +: BEAT_W] of the latched register and cnt increments.
  - On acceptance of beat NBEATS-1: next cycle state=IDLE, busy bit cleared, ld_done=1 for exactly that cycle, cnt wraps to 0.
  - ld_valid low stalls with no state change.
  - Beats arrive in strict ascending order, with no partial beats.
- ld_start in the cycle ld_done is high is accepted (state is IDLE); back-to-back loads have a 1-cycle gap minimum.
- ALU write:
  - When alu_we=1, for each element i with alu_mask[i]=1, reg[alu_waddr] element i <= alu_wdata0 element i.
  - If alu_pair=1, reg[(alu_waddr+1) mod NUM_REGS] element i <= alu_wdata1 element i with the same mask. Wrap-around: waddr=NUM_REGS-1 pairs with reg 0.
  - Masked-off elements hold.
- Collision, ALU write and load beat hit the same register in the same cycle: ALU wins on each element its mask enables; the load beat writes the remaining bits of its slice; the load counter advances normally.
- ALU write to a busy register is legal (no stall); busy_map is advisory for the issue logic.
- alu_pair with alu_mask=0 writes nothing. alu_we=0 ignores all alu_* inputs.

Test Plan:
- Reset/read: rst_n low mid-run -> all rd_data 0, busy_map=0x00, ld_start_ready=1 immediately (async), before the next clk edge.
- Full load:
  - Stimulus: ld_start with ld_reg=5, then 8 beats with ld_data=64'h1111_0000_0000_000k (k=0..7), valid every cycle.
  - Required: busy_map=0x20 during the load; ld_done pulses 1 cycle after the 8th beat; reg5 beat k = beat k data; busy_map=0 with ld_done.
- Stalled load:
  - Stimulus: same load with ld_valid toggled 1,0,0,1...; ld_start reasserted for reg 2 mid-load.
  - Required: counter advances only on valid beats; the reg 2 request is ignored; ld_done is still single-cycle.
- Masked/paired ALU:
  - Stimulus: alu_we=1, alu_pair=1, alu_waddr=7, alu_mask=16'h00FF, wdata0=all 0xAAAAAAAA, wdata1=all 0x55555555.
  - Required: reg7 elements 0-7 = 0xAAAAAAAA, reg0 (wrap-around) elements 0-7 = 0x55555555, elements 8-15 of both unchanged.
- Collision:
  - Stimulus: during a reg 3 load at beat 0, ALU writes reg 3 with mask=16'h0001 and data 0xDEADBEEF.
  - Required: bits[31:0]=0xDEADBEEF, bits[63:32] = beat 0 upper half; the load completes normally.
- Reset mid-load: rst_n low after 3 beats -> state IDLE, reg cleared, no ld_done pulse; a new load afterwards completes normally.
